// File: rtl/vend_ctrl_pkg.sv
// Shared encodings and coin constants for the vending controller slice.
package vend_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VEND   = 2'd1;
    localparam logic [1:0] ST_CHANGE = 2'd2;

    localparam int HALF_VAL = 1;
    localparam int ONE_VAL  = 2;
    localparam int SEL_W    = 2;

endpackage

// File: rtl/vend_timeout_cnt.sv
// Dispenser watchdog: counts cycles without vend_ack, flags the last allowed cycle.
module vend_timeout_cnt #(
    parameter int VEND_TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(VEND_TIMEOUT);
    localparam logic [W-1:0] LAST = W'(VEND_TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/vend_ctrl.sv
// Multi-product vending controller: credit accumulation, price check,
// dispense handshake with timeout refund, and coin-by-coin change payout.
module vend_ctrl
    import vend_ctrl_pkg::*;
#(
    parameter int CW           = 5,
    parameter int CREDIT_MAX   = 20,
    parameter int PRICE0       = 5,
    parameter int PRICE1       = 4,
    parameter int PRICE2       = 6,
    parameter int PRICE3       = 3,
    parameter int VEND_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             half,
    input  logic             one,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] sel,
    input  logic             cancel,
    input  logic             vend_ack,
    input  logic             chg_ack,
    output logic             vend_req,
    output logic [SEL_W-1:0] vend_id,
    output logic             chg_req,
    output logic [CW-1:0]    credit,
    output logic             busy,
    output logic             coin_reject,
    output logic             insufficient,
    output logic             fault
);

    localparam logic [CW:0] MAX_EXT = (CW+1)'(CREDIT_MAX);

    function automatic logic [CW-1:0] price_of(input logic [SEL_W-1:0] s);
        case (s)
            2'd0:    return CW'(PRICE0);
            2'd1:    return CW'(PRICE1);
            2'd2:    return CW'(PRICE2);
            default: return CW'(PRICE3);
        endcase
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    credit_q, credit_d;
    logic [SEL_W-1:0] vend_id_q, vend_id_d;
    logic             rej_q, rej_d;
    logic             insuf_q, insuf_d;
    logic             fault_q, fault_d;

    logic [1:0]    cv;
    logic [CW:0]   sum_ext;
    logic          coin_ok;
    logic [CW:0]   cv_acc;
    logic [CW-1:0] sel_price;
    logic          expired;

    // Coins are judged against the credit held before this cycle's selection.
    always_comb begin
        cv        = (half ? 2'(HALF_VAL) : 2'd0) + (one ? 2'(ONE_VAL) : 2'd0);
        sum_ext   = {1'b0, credit_q} + (CW+1)'(cv);
        coin_ok   = (sum_ext <= MAX_EXT);
        cv_acc    = coin_ok ? (CW+1)'(cv) : '0;
        sel_price = price_of(sel);
    end

    vend_timeout_cnt #(
        .VEND_TIMEOUT(VEND_TIMEOUT)
    ) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_q != ST_VEND),
        .en     ((state_q == ST_VEND) && !vend_ack),
        .expired(expired)
    );

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        vend_id_d = vend_id_q;
        rej_d     = 1'b0;
        insuf_d   = 1'b0;
        fault_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rej_d    = (cv != 2'd0) && !coin_ok;
                credit_d = credit_q + cv_acc[CW-1:0];
                if (cancel) begin
                    if (credit_q != '0) begin
                        state_d = ST_CHANGE;
                    end
                end else if (sel_valid) begin
                    if (credit_q >= sel_price) begin
                        vend_id_d = sel;
                        credit_d  = credit_q - sel_price + cv_acc[CW-1:0];
                        state_d   = ST_VEND;
                    end else begin
                        insuf_d = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                rej_d = (cv != 2'd0);
                if (vend_ack) begin
                    state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end else if (expired) begin
                    // Refund cannot overflow: credit held was >= price before the vend.
                    credit_d = credit_q + price_of(vend_id_q);
                    fault_d  = 1'b1;
                    state_d  = ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                rej_d = (cv != 2'd0);
                if (chg_ack && (credit_q != '0)) begin
                    credit_d = credit_q - 1'b1;
                    if (credit_q == CW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            credit_q  <= '0;
            vend_id_q <= '0;
            rej_q     <= 1'b0;
            insuf_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            vend_id_q <= vend_id_d;
            rej_q     <= rej_d;
            insuf_q   <= insuf_d;
            fault_q   <= fault_d;
        end
    end

    assign vend_req     = (state_q == ST_VEND);
    assign chg_req      = (state_q == ST_CHANGE);
    assign busy         = vend_req | chg_req;
    assign vend_id      = vend_id_q;
    assign credit       = credit_q;
    assign coin_reject  = rej_q;
    assign insufficient = insuf_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: each driven cycle queues the outputs expected after its edge.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       reset, half, one, sel_valid, cancel, vend_ack, chg_ack;
    logic [1:0] sel;
    logic       vend_req, chg_req, busy, coin_reject, insufficient, fault;
    logic [1:0] vend_id;
    logic [4:0] credit;

    typedef struct {
        string tag;
        int    cr;
        int    st;
        int    vid;
        int    rej;
        int    ins;
        int    flt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    vend_ctrl #(
        .VEND_TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .half        (half),
        .one         (one),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .cancel      (cancel),
        .vend_ack    (vend_ack),
        .chg_ack     (chg_ack),
        .vend_req    (vend_req),
        .vend_id     (vend_id),
        .chg_req     (chg_req),
        .credit      (credit),
        .busy        (busy),
        .coin_reject (coin_reject),
        .insufficient(insufficient),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // st: 0 idle, 1 vend, 2 change
    task automatic cyc(input string tag, input logic h, input logic o, input logic sv,
                       input logic [1:0] s, input logic c, input logic va, input logic ca,
                       input int cr, input int st, input int vid,
                       input int rej, input int ins, input int flt);
        exp_t e;
        half = h; one = o; sel_valid = sv; sel = s; cancel = c; vend_ack = va; chg_ack = ca;
        e.tag = tag; e.cr = cr; e.st = st; e.vid = vid; e.rej = rej; e.ins = ins; e.flt = flt;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check({mon_e.tag, ".credit"}, int'(credit), mon_e.cr);
            check({mon_e.tag, ".vend_req"}, int'(vend_req), int'(mon_e.st == 1));
            check({mon_e.tag, ".chg_req"}, int'(chg_req), int'(mon_e.st == 2));
            check({mon_e.tag, ".busy"}, int'(busy), int'(mon_e.st != 0));
            check({mon_e.tag, ".coin_reject"}, int'(coin_reject), mon_e.rej);
            check({mon_e.tag, ".insufficient"}, int'(insufficient), mon_e.ins);
            check({mon_e.tag, ".fault"}, int'(fault), mon_e.flt);
            if (mon_e.st == 1) check({mon_e.tag, ".vend_id"}, int'(vend_id), mon_e.vid);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; half = 1'b0; one = 1'b0; sel_valid = 1'b0; sel = 2'd0;
        cancel = 1'b0; vend_ack = 1'b0; chg_ack = 1'b0;

        // Basic purchase, exact money
        do_reset();
        cyc("t1_half",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc("t1_one",   0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        cyc("t1_one2",  0, 1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
        cyc("t1_sel0",  0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("t1_vwait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("t1_ack",   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t1_idle",  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // Purchase with change
        for (int i = 0; i < 3; i++) cyc("t2_one", 0, 1, 0, 0, 0, 0, 0, 2*(i+1), 0, 0, 0, 0, 0);
        cyc("t2_sel3", 0, 0, 1, 3, 0, 0, 0, 3, 1, 3, 0, 0, 0);
        cyc("t2_ack",  0, 0, 0, 0, 0, 1, 0, 3, 2, 0, 0, 0, 0);
        cyc("t2_hold", 0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0);
        for (int i = 2; i >= 0; i--) cyc("t2_chg", 0, 0, 0, 0, 0, 0, 1, i, (i == 0) ? 0 : 2, 0, 0, 0, 0);
        cyc("t2_idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Insufficient credit, cancel, cancel beats select
        cyc("t3_one",     0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        cyc("t3_sel2",    0, 0, 1, 2, 0, 0, 0, 2, 0, 0, 0, 1, 0);
        cyc("t3_after",   0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        cyc("t3_cancel",  0, 0, 0, 0, 1, 0, 0, 2, 2, 0, 0, 0, 0);
        cyc("t3_chg1",    0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0);
        cyc("t3_chg0",    0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("t3_cancel0", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("t3_one", 0, 1, 0, 0, 0, 0, 0, 2*(i+1), 0, 0, 0, 0, 0);
        cyc("t3_cxs",     0, 0, 1, 3, 1, 0, 0, 6, 2, 0, 0, 0, 0);
        for (int i = 5; i >= 0; i--) cyc("t3_chg", 0, 0, 0, 0, 0, 0, 1, i, (i == 0) ? 0 : 2, 0, 0, 0, 0);

        // Credit ceiling
        do_reset();
        for (int i = 0; i < 9; i++) cyc("t4_one", 0, 1, 0, 0, 0, 0, 0, 2*(i+1), 0, 0, 0, 0, 0);
        cyc("t4_half19", 1, 0, 0, 0, 0, 0, 0, 19, 0, 0, 0, 0, 0);
        cyc("t4_rej19",  0, 1, 0, 0, 0, 0, 0, 19, 0, 0, 1, 0, 0);
        cyc("t4_half20", 1, 0, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0, 0);
        cyc("t4_rej20",  1, 1, 0, 0, 0, 0, 0, 20, 0, 0, 1, 0, 0);
        cyc("t4_idle20", 0, 0, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 8; i++) cyc("t4_one", 0, 1, 0, 0, 0, 0, 0, 2*(i+1), 0, 0, 0, 0, 0);
        cyc("t4_half17", 1, 0, 0, 0, 0, 0, 0, 17, 0, 0, 0, 0, 0);
        cyc("t4_both",   1, 1, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0, 0);
        cyc("t4_sel3",   0, 0, 1, 3, 0, 0, 0, 17, 1, 3, 0, 0, 0);
        cyc("t4_vcoin",  1, 0, 0, 0, 0, 0, 0, 17, 1, 3, 1, 0, 0);
        cyc("t4_ack",    0, 0, 0, 0, 0, 1, 0, 17, 2, 0, 0, 0, 0);

        // Dispenser timeout refund
        do_reset();
        cyc("t5_one",  0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        cyc("t5_one2", 0, 1, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
        cyc("t5_half", 1, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
        cyc("t5_sel0", 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc("t5_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("t5_tmo", 0, 0, 0, 0, 0, 0, 0, 5, 2, 0, 0, 0, 1);
        for (int i = 4; i >= 0; i--) cyc("t5_chg", 0, 0, 0, 0, 0, 0, 1, i, (i == 0) ? 0 : 2, 0, 0, 0, 0);
        cyc("t5b_one",  0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        cyc("t5b_one2", 0, 1, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
        cyc("t5b_half", 1, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
        cyc("t5b_sel0", 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc("t5b_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("t5b_ack8", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5b_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset during change payout
        do_reset();
        cyc("t6_one",    0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        cyc("t6_half",   1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        cyc("t6_cancel", 0, 0, 0, 0, 1, 0, 0, 3, 2, 0, 0, 0, 0);
        reset = 1'b1;
        cyc("t6_rst",    0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc("t6_idle",   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #2;
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
